// File: rtl/soc_loader_pkg.sv
// Shared types and helpers for the framed byte-stream memory loader.
package soc_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TGT,
        ADDR0,
        ADDR1,
        LEN0,
        LEN1,
        DATA,
        CHK
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int lanes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/soc_loader_word_pack.sv
// Byte-lane assembly into memory words with strobe accumulation and a
// registered write port (one-cycle write pulse per flushed word).
module soc_loader_word_pack
    import soc_loader_pkg::*;
#(
    parameter int NUM_TGT    = 2,
    parameter int TGT_W      = 1,
    parameter int DATA_WIDTH = 32,
    parameter int WADDR_W    = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           drop,
    input  logic                           byte_vld,
    input  logic [7:0]                     byte_data,
    input  logic [lane_bits(DATA_WIDTH)-1:0] lane,
    input  logic [WADDR_W-1:0]             waddr,
    input  logic [TGT_W-1:0]               tgt,
    input  logic                           last,
    output logic [NUM_TGT-1:0]             mem_wr_en,
    output logic [WADDR_W-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic [DATA_WIDTH/8-1:0]        mem_wstrb
);

    localparam int LANES     = lanes(DATA_WIDTH);
    localparam int LANE_BITS = lane_bits(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d, new_data;
    logic [LANES-1:0]      acc_strb_q, acc_strb_d, new_strb;
    logic [NUM_TGT-1:0]    wr_en_q, wr_en_d;
    logic [WADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LANES-1:0]      wstrb_q, wstrb_d;

    always_comb begin
        acc_data_d = acc_data_q;
        acc_strb_d = acc_strb_q;
        wr_en_d    = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = '0;
        new_data   = acc_data_q | (DATA_WIDTH'(byte_data) << {lane, 3'b000});
        new_strb   = acc_strb_q | (LANES'(1) << lane);
        if (drop) begin
            // Aborted frame: the partial word is discarded, never written.
            acc_data_d = '0;
            acc_strb_d = '0;
        end else if (byte_vld) begin
            if (lane == LANE_BITS'(LANES - 1) || last) begin
                wr_en_d    = NUM_TGT'(1) << tgt;
                addr_d     = waddr;
                wdata_d    = new_data;
                wstrb_d    = new_strb;
                acc_data_d = '0;
                acc_strb_d = '0;
            end else begin
                acc_data_d = new_data;
                acc_strb_d = new_strb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_data_q <= '0;
            acc_strb_q <= '0;
            wr_en_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_strb_q <= acc_strb_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    assign mem_wr_en = wr_en_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: rtl/soc_mem_loader.sv
// Frame parser for the byte-stream loader: header capture, address/length
// counting, checksum and done/error reporting; word packing is delegated.
module soc_mem_loader
    import soc_loader_pkg::*;
#(
    parameter int         NUM_TGT    = 2,
    parameter int         ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] SYNC_BYTE  = soc_loader_pkg::SYNC_BYTE
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              load_en,
    input  logic                                              rx_valid,
    input  logic [7:0]                                        rx_data,
    output logic                                              rx_ready,
    output logic [NUM_TGT-1:0]                                mem_wr_en,
    output logic [ADDR_WIDTH-lane_bits(DATA_WIDTH)-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]                             mem_wdata,
    output logic [DATA_WIDTH/8-1:0]                           mem_wstrb,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              error
);

    localparam int LANE_BITS = lane_bits(DATA_WIDTH);
    localparam int WADDR_W   = ADDR_WIDTH - LANE_BITS;
    localparam int TGT_W     = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    state_e                state_q, state_d;
    logic [TGT_W-1:0]      tgt_q, tgt_d;
    logic [7:0]            addr_lo_q, addr_lo_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            sum_q, sum_d, chk_sum;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  pk_vld, pk_last;

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        addr_lo_d = addr_lo_q;
        len_lo_d  = len_lo_q;
        baddr_d   = baddr_q;
        len_d     = len_q;
        sum_d     = sum_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        pk_vld    = 1'b0;
        pk_last   = 1'b0;
        chk_sum   = sum_q + rx_data;
        if (!load_en) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = TGT;
                        sum_d   = '0;
                    end
                end
                TGT: begin
                    if (int'(rx_data) >= NUM_TGT) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tgt_d   = TGT_W'(rx_data);
                        state_d = ADDR0;
                    end
                end
                ADDR0: begin
                    addr_lo_d = rx_data;
                    state_d   = ADDR1;
                end
                ADDR1: begin
                    baddr_d = ADDR_WIDTH'({rx_data, addr_lo_q});
                    state_d = LEN0;
                end
                LEN0: begin
                    len_lo_d = rx_data;
                    state_d  = LEN1;
                end
                LEN1: begin
                    len_d   = {rx_data, len_lo_q};
                    state_d = (len_d == 16'd0) ? CHK : DATA;
                end
                DATA: begin
                    // len_q counts payload bytes still to come, this one included.
                    pk_vld  = 1'b1;
                    pk_last = (len_q == 16'd1);
                    baddr_d = baddr_q + 1'b1;
                    len_d   = len_q - 16'd1;
                    sum_d   = chk_sum;
                    if (pk_last) state_d = CHK;
                end
                CHK: begin
                    done_d  = (chk_sum == 8'd0);
                    error_d = (chk_sum != 8'd0);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            addr_lo_q <= '0;
            len_lo_q  <= '0;
            baddr_q   <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            addr_lo_q <= addr_lo_d;
            len_lo_q  <= len_lo_d;
            baddr_q   <= baddr_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    soc_loader_word_pack #(
        .NUM_TGT    (NUM_TGT),
        .TGT_W      (TGT_W),
        .DATA_WIDTH (DATA_WIDTH),
        .WADDR_W    (WADDR_W)
    ) u_word_pack (
        .clk       (clk),
        .reset     (reset),
        .drop      (!load_en),
        .byte_vld  (pk_vld),
        .byte_data (rx_data),
        .lane      (baddr_q[LANE_BITS-1:0]),
        .waddr     (baddr_q[ADDR_WIDTH-1:LANE_BITS]),
        .tgt       (tgt_q),
        .last      (pk_last),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    assign rx_ready = load_en;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_soc_mem_loader.sv
// Randomized frame stimulus checked against a word-grouping reference model.
module tb_soc_mem_loader;

    logic        clk = 1'b0;
    logic        reset, load_en, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, busy, done, error;
    logic [1:0]  mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    soc_mem_loader #(.NUM_TGT(2), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          wen;
        int          addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
    } wr_t;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_ovl_cnt = 0;
    wr_t  got_q[$], exp_q[$], sav_q[$];
    wr_t  mon_w;
    logic [7:0] pay_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wr_en != 2'b00) begin
            mon_w.wen  = int'(mem_wr_en);
            mon_w.addr = int'(mem_addr);
            mon_w.data = mem_wdata;
            mon_w.strb = mem_wstrb;
            mon_w.cyc  = cyc;
            got_q.push_back(mon_w);
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
        if ((done || error) && busy) busy_ovl_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        c        = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Sends one frame with payload pay_q; the model groups consecutive byte
    // addresses by word and expects one write per touched word.
    task automatic run_frame(input int tgt, input int addr, input bit bad);
        int         c, len, ba, lane;
        int         pc[$];
        logic [7:0] sum, ck;
        logic [31:0] d;
        logic [3:0]  s;
        wr_t         w;
        len = pay_q.size();
        sum = 8'd0;
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        send_byte(8'hA5, c);
        send_byte(8'(tgt), c);
        send_byte(8'(addr), c);
        send_byte(8'(addr >> 8), c);
        send_byte(8'(len), c);
        send_byte(8'(len >> 8), c);
        foreach (pay_q[i]) begin
            send_byte(pay_q[i], c);
            pc.push_back(c);
            sum = sum + pay_q[i];
        end
        ck = 8'd0 - sum;
        if (bad) ck = ck + 8'($urandom_range(1, 255));
        send_byte(ck, c);
        idle(1);
        check("frame_done", done, !bad);
        check("frame_error", error, bad);
        check("frame_busy", busy, 0);
        idle(2);
        d = '0;
        s = '0;
        for (int i = 0; i < len; i++) begin
            ba   = (addr + i) % 4096;
            lane = ba % 4;
            d[lane*8 +: 8] = pay_q[i];
            s[lane] = 1'b1;
            if (lane == 3 || i == len - 1) begin
                w.wen = 1 << tgt; w.addr = ba / 4; w.data = d; w.strb = s; w.cyc = pc[i] + 1;
                exp_q.push_back(w);
                d = '0;
                s = '0;
            end
        end
        check("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("wr_en", got_q[i].wen, exp_q[i].wen);
            check("wr_addr", got_q[i].addr, exp_q[i].addr);
            check("wr_data", got_q[i].data, exp_q[i].data);
            check("wr_strb", got_q[i].strb, exp_q[i].strb);
            check("wr_cycle", got_q[i].cyc, exp_q[i].cyc);
        end
        check("done_cnt", done_cnt, !bad);
        check("err_cnt", err_cnt, bad);
        sav_q = got_q;
    endtask

    task automatic run_bad_tgt(input int tgt);
        int c;
        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        send_byte(8'hA5, c);
        send_byte(8'(tgt), c);
        idle(1);
        check("badtgt_error", error, 1);
        check("badtgt_busy", busy, 0);
        repeat (6) send_byte(8'($urandom_range(0, 8'hA4)), c);
        idle(2);
        check("badtgt_writes", got_q.size(), 0);
        check("badtgt_err_cnt", err_cnt, 1);
        check("badtgt_done_cnt", done_cnt, 0);
    endtask

    task automatic send_partial(input int tgt);
        int c;
        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        send_byte(8'hA5, c);
        send_byte(8'(tgt), c);
        send_byte(8'h00, c);
        send_byte(8'h00, c);
        send_byte(8'h08, c);
        send_byte(8'h00, c);
        send_byte(8'h11, c);
        send_byte(8'h22, c);
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_ready_off", rx_ready, 0);
        reset = 1'b1;
        load_en = 1'b1;
        @(negedge clk);
        check("ready_on", rx_ready, 1);

        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame(0, 0, 0);
        if (sav_q.size() >= 2) begin
            check("aligned_w0", sav_q[0].data, 32'h44332211);
            check("aligned_w1", sav_q[1].data, 32'h88776655);
            check("aligned_s1", sav_q[1].strb, 4'hF);
        end

        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        run_frame(1, 2, 0);
        if (sav_q.size() >= 2) begin
            check("unal_w0", sav_q[0].data, 32'hBBAA0000);
            check("unal_s0", sav_q[0].strb, 4'hC);
            check("unal_w1", sav_q[1].data, 32'h000000CC);
            check("unal_en", sav_q[1].wen, 2);
        end

        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame(0, 0, 1);
        run_frame(0, 0, 0);

        run_bad_tgt(2);

        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(0, 12'hFFE, 0);
        if (sav_q.size() >= 2) begin
            check("wrap_a0", sav_q[0].addr, 10'h3FF);
            check("wrap_s0", sav_q[0].strb, 4'hC);
            check("wrap_a1", sav_q[1].addr, 0);
            check("wrap_s1", sav_q[1].strb, 4'h3);
        end

        pay_q.delete();
        run_frame(0, 0, 0);

        // Abort by load_en, then make sure no stale lanes leak into the next word.
        send_partial(0);
        @(negedge clk);
        load_en = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h33;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_ready", rx_ready, 0);
        rx_valid = 1'b0;
        load_en = 1'b1;
        idle(3);
        check("abort_writes", got_q.size(), 0);
        check("abort_done", done_cnt, 0);
        check("abort_err", err_cnt, 0);
        pay_q = '{8'h5A, 8'h6B};
        run_frame(0, 2, 0);

        send_partial(1);
        @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("mrst_wr_en", mem_wr_en, 0);
        check("mrst_addr", mem_addr, 0);
        check("mrst_wdata", mem_wdata, 0);
        check("mrst_wstrb", mem_wstrb, 0);
        check("mrst_busy", busy, 0);
        check("mrst_flags", {done, error}, 0);
        reset = 1'b1;
        idle(2);
        check("mrst_writes", got_q.size(), 0);
        pay_q = '{8'hC3, 8'hD4};
        run_frame(1, 2, 0);

        for (int f = 0; f < 40; f++) begin
            int n, a;
            if (f % 5 == 4) begin
                run_bad_tgt($urandom_range(2, 255));
            end else begin
                n = $urandom_range(0, 12);
                a = ($urandom_range(0, 3) == 0) ? $urandom_range(4085, 4095) : $urandom_range(0, 4095);
                pay_q.delete();
                for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
                run_frame($urandom_range(0, 1), a, $urandom_range(0, 3) == 0);
            end
        end

        check("done_err_overlap", both_cnt, 0);
        check("busy_flag_overlap", busy_ovl_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
